// File: rtl/freq_gate_sequencer.sv
// Equal-precision frequency-meter sequencer: opens/closes a counting gate on
// synchronized signal rising edges and publishes reference/signal counts.
module freq_gate_sequencer #(
  parameter int CNT_W       = 32,
  parameter int GATE_W      = 32,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic              sysClk,
  input  logic              sysRst,
  input  logic              signal,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic [GATE_W-1:0] gateCycles,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  refCount,
  output logic [CNT_W-1:0]  sigCount,
  output logic              overflow,
  output logic              timeout
);

  localparam int IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int CMP_W  = (CNT_W > GATE_W) ? CNT_W : GATE_W;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_GATE} state_t;

  state_t              state_q, state_d;
  logic                sync1_q, sync2_q, hist_q;
  logic [GATE_W-1:0]   gL_q, gL_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [CNT_W-1:0]    refBuf_q, refBuf_d, sigBuf_q, sigBuf_d;
  logic                ovfBuf_q, ovfBuf_d;
  logic                done_q, done_d, timeout_q, timeout_d, overflow_q, overflow_d;
  logic [CNT_W-1:0]    refCount_q, refCount_d, sigCount_q, sigCount_d;

  logic                sigEdge, refSat, closeHit, idleHit;
  logic [CNT_W-1:0]    refNext, sigNext;
  logic [GATE_W-1:0]   gNew;

  // Both gate boundaries share the same synchronizer delay, so it cancels.
  assign sigEdge  = sync2_q & ~hist_q;
  assign refSat   = &refBuf_q;
  assign refNext  = refSat ? refBuf_q : refBuf_q + CNT_W'(1);
  assign sigNext  = sigBuf_q + CNT_W'(sigEdge);
  assign closeHit = sigEdge && (CMP_W'(refNext) >= CMP_W'(gL_q));
  assign idleHit  = !sigEdge && (idle_q == IDLE_LAST);
  assign gNew     = (gateCycles == '0) ? GATE_W'(1) : gateCycles;

  always_comb begin
    state_d    = state_q;
    gL_d       = gL_q;
    idle_d     = idle_q;
    refBuf_d   = refBuf_q;
    sigBuf_d   = sigBuf_q;
    ovfBuf_d   = ovfBuf_q;
    done_d     = 1'b0;
    timeout_d  = timeout_q;
    overflow_d = overflow_q;
    refCount_d = refCount_q;
    sigCount_d = sigCount_q;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          gL_d    = gNew;
          idle_d  = '0;
          state_d = S_ARM;
        end
        S_ARM: begin
          if (idleHit) begin
            done_d    = 1'b1;
            timeout_d = 1'b1;
            state_d   = S_IDLE;
          end else if (sigEdge) begin
            refBuf_d = '0;
            sigBuf_d = '0;
            ovfBuf_d = 1'b0;
            idle_d   = '0;
            state_d  = S_GATE;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end
        S_GATE: begin
          idle_d = sigEdge ? '0 : idle_q + IDLE_W'(1);
          if (idleHit) begin
            done_d    = 1'b1;
            timeout_d = 1'b1;
            state_d   = S_IDLE;
          end else if (closeHit) begin
            refCount_d = refNext;
            sigCount_d = sigNext;
            overflow_d = ovfBuf_q | refSat;
            timeout_d  = 1'b0;
            done_d     = 1'b1;
            // The closing edge doubles as the next opening edge: no dead time.
            if (continuous) begin
              refBuf_d = '0;
              sigBuf_d = '0;
              ovfBuf_d = 1'b0;
              gL_d     = gNew;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            refBuf_d = refNext;
            sigBuf_d = sigNext;
            ovfBuf_d = ovfBuf_q | refSat;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sysClk or posedge sysRst) begin
    if (sysRst) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      hist_q     <= 1'b0;
      gL_q       <= '0;
      idle_q     <= '0;
      refBuf_q   <= '0;
      sigBuf_q   <= '0;
      ovfBuf_q   <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      refCount_q <= '0;
      sigCount_q <= '0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= signal;
      sync2_q    <= sync1_q;
      hist_q     <= sync2_q;
      gL_q       <= gL_d;
      idle_q     <= idle_d;
      refBuf_q   <= refBuf_d;
      sigBuf_q   <= sigBuf_d;
      ovfBuf_q   <= ovfBuf_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
      refCount_q <= refCount_d;
      sigCount_q <= sigCount_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign refCount = refCount_q;
  assign sigCount = sigCount_q;
  assign overflow = overflow_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_freq_gate_sequencer.sv
// Directed bench for freq_gate_sequencer: a 32-bit-counter instance plus an
// 8-bit-counter instance for the saturation case.
module tb_freq_gate_sequencer;

  logic        sysClk = 1'b0;
  logic        sysRst = 1'b0;
  logic        signal = 1'b0;
  logic        start = 1'b0, start8 = 1'b0, stop = 1'b0, continuous = 1'b0;
  logic [31:0] gateCycles = 32'd100;
  logic        busy, done, overflow, timeout;
  logic [31:0] refCount, sigCount;
  logic        busy8, done8, overflow8, timeout8;
  logic [7:0]  refCount8, sigCount8;

  int total = 0;
  int bad   = 0;
  int sigPer = 10;
  bit sigEn  = 1'b0;
  int ph     = 0;

  freq_gate_sequencer #(.CNT_W(32), .GATE_W(32), .TIMEOUT_CYC(1000)) dut (
    .sysClk(sysClk), .sysRst(sysRst), .signal(signal), .start(start), .stop(stop),
    .continuous(continuous), .gateCycles(gateCycles), .busy(busy), .done(done),
    .refCount(refCount), .sigCount(sigCount), .overflow(overflow), .timeout(timeout));

  freq_gate_sequencer #(.CNT_W(8), .GATE_W(32), .TIMEOUT_CYC(1000)) dut8 (
    .sysClk(sysClk), .sysRst(sysRst), .signal(signal), .start(start8), .stop(stop),
    .continuous(1'b0), .gateCycles(gateCycles), .busy(busy8), .done(done8),
    .refCount(refCount8), .sigCount(sigCount8), .overflow(overflow8), .timeout(timeout8));

  always #5 sysClk = ~sysClk;

  // Measured signal: rising edge every sigPer sysClk cycles while enabled.
  initial forever begin
    @(negedge sysClk);
    if (sigEn) begin
      ph = (ph + 1 >= sigPer) ? 0 : ph + 1;
      signal = (ph < sigPer / 2);
    end else begin
      ph = 0;
      signal = 1'b0;
    end
  end

  task automatic wait_done(input int maxc, input bit use8, output bit got, output int n);
    got = 1'b0;
    n = 0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge sysClk); #1;
      n = i + 1;
      if (use8 ? done8 : done) begin
        got = 1'b1;
        return;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge sysClk); start = 1'b1;
    @(negedge sysClk); start = 1'b0;
  endtask

  task automatic test_reset();
    sysRst = 1'b1;
    #1;
    total++;
    if ({busy, done, overflow, timeout, refCount, sigCount} !== '0) begin
      bad++; $display("FAIL reset32 got busy=%b done=%b ref=%0d sig=%0d ovf=%b to=%b want all 0",
                      busy, done, refCount, sigCount, overflow, timeout);
    end
    total++;
    if ({busy8, done8, overflow8, timeout8, refCount8, sigCount8} !== '0) begin
      bad++; $display("FAIL reset8 got ref=%0d sig=%0d want all 0", refCount8, sigCount8);
    end
    repeat (3) @(negedge sysClk);
    sysRst = 1'b0;
    repeat (2) @(negedge sysClk);
  endtask

  task automatic measure(input string nm, input int per, input int gate,
                         input int eRef, input int eSig);
    bit got; int n;
    sigPer = per; gateCycles = gate; sigEn = 1'b1;
    repeat (3 * per) @(negedge sysClk);
    pulse_start();
    wait_done(3000, 1'b0, got, n);
    total++;
    if (!got || refCount !== eRef || sigCount !== eSig || overflow !== 1'b0 ||
        timeout !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s got done=%b ref=%0d sig=%0d ovf=%b to=%b busy=%b want ref=%0d sig=%0d ovf=0 to=0 busy=0",
                      nm, got, refCount, sigCount, overflow, timeout, busy, eRef, eSig);
    end
    @(posedge sysClk); #1;
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL %s_pulse got done=%b want 0 one cycle later", nm, done);
    end
  endtask

  task automatic test_basic();
    measure("basic_p10_g100", 10, 100, 100, 10);
    measure("period7_g100", 7, 100, 105, 15);
  endtask

  task automatic test_boundary();
    measure("edge_equals_gate", 10, 10, 10, 1);
    measure("gate_zero", 10, 0, 10, 1);
  endtask

  task automatic test_continuous();
    bit got; int n;
    sigPer = 10; gateCycles = 50; continuous = 1'b1;
    pulse_start();
    wait_done(500, 1'b0, got, n);
    total++;
    if (!got) begin bad++; $display("FAIL cont_first got no done want done"); end
    for (int k = 0; k < 3; k++) begin
      wait_done(200, 1'b0, got, n);
      total++;
      if (!got || n !== 50 || refCount !== 50 || sigCount !== 5 || busy !== 1'b1) begin
        bad++; $display("FAIL cont_spacing%0d got done=%b gap=%0d ref=%0d sig=%0d busy=%b want gap=50 ref=50 sig=5 busy=1",
                        k, got, n, refCount, sigCount, busy);
      end
    end
    @(negedge sysClk); continuous = 1'b0;
    wait_done(200, 1'b0, got, n);
    total++;
    if (!got || n !== 50 || refCount !== 50 || sigCount !== 5 || busy !== 1'b0) begin
      bad++; $display("FAIL cont_drop got done=%b gap=%0d ref=%0d sig=%0d busy=%b want gap=50 ref=50 sig=5 busy=0",
                      got, n, refCount, sigCount, busy);
    end
    wait_done(150, 1'b0, got, n);
    total++;
    if (got || busy !== 1'b0) begin
      bad++; $display("FAIL cont_stopped got done=%b busy=%b want no done busy=0", got, busy);
    end
  endtask

  task automatic test_timeout();
    bit got; int n;
    sigEn = 1'b0;
    repeat (10) @(negedge sysClk);
    @(negedge sysClk); start = 1'b1;
    @(posedge sysClk); #1; start = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_rise got %b want 1", busy); end
    wait_done(1200, 1'b0, got, n);
    total++;
    if (!got || n !== 1000 || timeout !== 1'b1 || busy !== 1'b0 ||
        refCount !== 50 || sigCount !== 5 || overflow !== 1'b0) begin
      bad++; $display("FAIL timeout got done=%b after=%0d to=%b busy=%b ref=%0d sig=%0d ovf=%b want after=1000 to=1 busy=0 ref=50 sig=5 ovf=0",
                      got, n, timeout, busy, refCount, sigCount, overflow);
    end
  endtask

  task automatic test_overflow();
    bit got; int n;
    sigPer = 300; gateCycles = 10; sigEn = 1'b1;
    @(negedge sysClk); start8 = 1'b1;
    @(negedge sysClk); start8 = 1'b0;
    wait_done(1500, 1'b1, got, n);
    total++;
    if (!got || refCount8 !== 8'd255 || sigCount8 !== 8'd1 || overflow8 !== 1'b1 || timeout8 !== 1'b0) begin
      bad++; $display("FAIL overflow8 got done=%b ref=%0d sig=%0d ovf=%b to=%b want ref=255 sig=1 ovf=1 to=0",
                      got, refCount8, sigCount8, overflow8, timeout8);
    end
  endtask

  task automatic test_stop();
    bit got; int n;
    sigPer = 10; gateCycles = 100;
    repeat (20) @(negedge sysClk);
    pulse_start();
    repeat (40) @(negedge sysClk);
    stop = 1'b1;
    @(negedge sysClk); stop = 1'b0;
    wait_done(200, 1'b0, got, n);
    total++;
    if (got || busy !== 1'b0 || refCount !== 50 || sigCount !== 5 || timeout !== 1'b1) begin
      bad++; $display("FAIL stop got done=%b busy=%b ref=%0d sig=%0d to=%b want no done busy=0 ref=50 sig=5 to=1",
                      got, busy, refCount, sigCount, timeout);
    end
  endtask

  task automatic test_reset_mid();
    bit got; int n;
    pulse_start();
    repeat (40) @(negedge sysClk);
    sysRst = 1'b1;
    #1;
    total++;
    if ({busy, done, overflow, timeout, refCount, sigCount} !== '0) begin
      bad++; $display("FAIL reset_mid got busy=%b ref=%0d sig=%0d to=%b want all 0",
                      busy, refCount, sigCount, timeout);
    end
    @(negedge sysClk); sysRst = 1'b0;
    wait_done(200, 1'b0, got, n);
    total++;
    if (got || busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid_quiet got done=%b busy=%b want no done busy=0", got, busy);
    end
    measure("after_reset", 10, 100, 100, 10);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_continuous();
    test_timeout();
    test_overflow();
    test_stop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/freq_gate_sequencer.md
# freq_gate_sequencer

Measurement sequencer for the frequency-meter datapath, using the equal-precision (reciprocal) method. It opens and closes a counting gate aligned to rising edges of the measured signal, so every result spans a whole number of signal periods. Over one gate it counts sysClk cycles and signal edges, then publishes both counts with a done pulse. It sits between the host control registers and the result registers, and replaces free-running gate toggling with a start/stop/continuous handshake plus timeout and overflow reporting.

## Interface
Parameters:
- CNT_W, 32, width of both result counters.
- GATE_W, 32, width of the programmed minimum gate length.
- TIMEOUT_CYC, 50_000_000, number of consecutive sysClk cycles without a signal edge before a measurement is aborted with timeout.

Ports:
- sysClk  in  1  system clock; all logic is in this domain.
- sysRst  in  1  asynchronous, active-high reset.
- signal  in  1  measured signal, asynchronous to sysClk; frequency must be below sysClk/2.
- start  in  1  level-sampled; begins a measurement when the block is idle.
- stop  in  1  aborts any measurement; has priority over start.
- continuous  in  1  when 1, each closing edge also opens the next gate.
- gateCycles  in  GATE_W  minimum gate length in sysClk cycles; latched at start; 0 is treated as 1.
- busy  out  1  1 whenever state is not IDLE.
- done  out  1  one-cycle pulse marking a new result or a timeout.
- refCount  out  CNT_W  sysClk cycles spanned by the gate.
- sigCount  out  CNT_W  signal periods spanned by the gate.
- overflow  out  1  refCount saturated during the reported gate.
- timeout  out  1  the reported measurement ended by timeout.

## Operation
- Synchronizer: signal passes through 2 flops, then 1 history flop. sigEdge is 1 for one cycle when the synchronized value goes 0→1. Both gate boundaries see the same 3-cycle delay, so the delay cancels out of the result.
- States: IDLE, ARM, GATE.
- IDLE:
  - start=1 and stop=0: latch gL = max(gateCycles,1), clear idleCnt, go to ARM.
- ARM:
  - sigEdge: refBuf←0, sigBuf←0, clear idleCnt, go to GATE. This edge is the opening edge.
- GATE, every cycle:
  - ref' = refBuf+1, saturating at all-ones; saturation sets ovfBuf.
  - sig' = sigBuf + sigEdge.
  - Close condition: sigEdge=1 and ref' ≥ gL. On close:
    - refCount←ref', sigCount←sig', overflow←ovfBuf, timeout←0, done←1.
    - If continuous=1: stay in GATE with refBuf←0, sigBuf←0, ovfBuf←0, and re-latch gL from gateCycles. There is no dead time between gates.
    - Otherwise go to IDLE.
  - If the close condition is false: refBuf←ref', sigBuf←sig'.
- Timeout:
  - In ARM or GATE, idleCnt increments every cycle with no sigEdge and clears on sigEdge.
  - At idleCnt = TIMEOUT_CYC−1 with no edge: done←1, timeout←1, go to IDLE.
  - refCount, sigCount and overflow keep their previous values.
- stop=1 in any state: go to IDLE next cycle. No done pulse; outputs are not changed.
- start while busy is ignored. gateCycles changes during a gate have no effect on that gate.
- Result definition: ref = sysClk cycles from the opening edge to the closing edge; sig = signal edges after the opening edge, up to and including the closing edge.

## Timing
- Reset values: state IDLE, busy 0, done 0, refCount 0, sigCount 0, overflow 0, timeout 0; all internal counters 0.
- Reset asserted mid-measurement returns everything to reset values at once. No done pulse is produced.
- busy rises 1 cycle after start is sampled.
- Opening latency: GATE is entered on the first sysClk edge after sigEdge is seen, i.e. 3–4 sysClk cycles after the raw signal rises.
- Result latency: refCount, sigCount and done update on the same sysClk edge, 1 cycle after the closing-edge cycle. Results hold until the next done.
- done is high for exactly 1 cycle per result, including back-to-back results in continuous mode.
- If an edge falls in the same cycle that ref' first reaches gL, it closes the gate (condition is ≥, not >).
- If stop and a close happen in the same cycle, stop wins: no done, no update.

## Test plan
- Signal period 10 sysClk, gateCycles=100, start pulse → one done; refCount=100, sigCount=10, overflow=0, timeout=0, busy falls with done.
- Signal period 7, gateCycles=100 → closes on the first edge at ref' ≥ 100: refCount=105, sigCount=15.
- continuous=1, period 10, gateCycles=50 → successive done pulses exactly 50 cycles apart, each with refCount=50, sigCount=5. Drop continuous → stops after the next result.
- Signal held low, TIMEOUT_CYC=1000 → done with timeout=1 exactly 1000 cycles after ARM entry; previous refCount/sigCount unchanged; busy=0.
- CNT_W=8, period 300, gateCycles=10 → refCount=255, sigCount=1, overflow=1.
- stop mid-GATE, and sysRst mid-GATE → IDLE with no done. After reset, all outputs 0. A new start then measures correctly.
